// File: rtl/neuron_scheduler.sv
// Purpose: time-multiplexes one external LIF datapath across N_NEURONS neurons, holding weights, potentials, spike flags and globals.
// Latency: a step accepted at edge k evaluates one neuron per cycle in k+1..k+N; spikes_valid pulses in cycle k+N+1.
// Backpressure: cfg_ready/step_ready are low throughout EVAL; config wins over a simultaneous step request in IDLE.
module neuron_scheduler #(
  parameter int n_stage   = 2,
  parameter int N_NEURONS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [3:0]               cfg_addr,
  input  logic [7:0]               cfg_data,
  input  logic                     step_valid,
  output logic                     step_ready,
  input  logic [(2**n_stage)-1:0]  x,
  output logic [N_NEURONS-1:0]     spikes,
  output logic [3:0]               spike_count,
  output logic                     spikes_valid,
  output logic                     busy,
  output logic [(2**n_stage)-1:0]  dp_w,
  output logic [(2**n_stage)-1:0]  dp_x,
  output logic [2:0]               dp_shift,
  output logic [n_stage+1:0]       dp_previus_u,
  output logic [n_stage+1:0]       dp_minus_teta,
  output logic                     dp_was_spike,
  input  logic [n_stage+1:0]       dp_u_out,
  input  logic                     dp_is_spike
);

  localparam int W  = 2**n_stage;
  localparam int U  = n_stage + 2;
  localparam int IW = 3;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_EVAL = 1'b1;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);

  // Architectural state
  logic                 r_state;
  logic [W-1:0]         r_wreg [N_NEURONS];
  logic [U-1:0]         r_ureg [N_NEURONS];
  logic [N_NEURONS-1:0] r_sreg;
  logic [2:0]           r_shift;
  logic [U-1:0]         r_teta;
  logic [W-1:0]         r_x;
  logic [IW-1:0]        r_idx;
  logic [N_NEURONS-1:0] r_acc;
  logic [N_NEURONS-1:0] r_spikes;
  logic [3:0]           r_count;
  logic                 r_spikes_vld;

  // Combinational helpers
  logic                 w_cfg_fire;
  logic                 w_step_fire;
  logic                 w_last;
  logic [W-1:0]         w_cur_w;
  logic [U-1:0]         w_cur_u;
  logic                 w_cur_s;
  logic [N_NEURONS-1:0] w_final;
  logic [3:0]           w_final_cnt;
  logic [15:0]          w_cfg_ext;
  logic [W-1:0]         w_cfg_w;
  logic [U-1:0]         w_cfg_u;
  logic                 w_unused_cfg;

  assign cfg_ready   = (r_state == S_IDLE);
  assign step_ready  = (r_state == S_IDLE) & ~cfg_valid;
  assign busy        = (r_state == S_EVAL);
  assign w_cfg_fire  = cfg_valid & cfg_ready;
  assign w_step_fire = step_valid & step_ready;
  assign w_last      = (r_idx == LAST_IDX);

  // Config data is zero-extended so weight/threshold fields of any width slice cleanly.
  assign w_cfg_ext    = 16'(cfg_data);
  assign w_cfg_w      = w_cfg_ext[W-1:0];
  assign w_cfg_u      = w_cfg_ext[U-1:0];
  assign w_unused_cfg = ^w_cfg_ext;

  assign spikes        = r_spikes;
  assign spike_count   = r_count;
  assign spikes_valid  = r_spikes_vld;
  assign dp_w          = w_cur_w;
  assign dp_previus_u  = w_cur_u;
  assign dp_was_spike  = w_cur_s;
  assign dp_x          = (r_state == S_EVAL) ? r_x : '0;
  assign dp_shift      = r_shift;
  assign dp_minus_teta = r_teta;

  // Select the stored state of the neuron currently addressed by r_idx.
  always_comb begin
    w_cur_w = r_wreg[0];
    w_cur_u = r_ureg[0];
    w_cur_s = r_sreg[0];
    for (int i = 1; i < N_NEURONS; i++) begin
      if (r_idx == IW'(i)) begin
        w_cur_w = r_wreg[i];
        w_cur_u = r_ureg[i];
        w_cur_s = r_sreg[i];
      end
    end
  end

  // Spike vector as it will be after this cycle's neuron lands, plus its popcount.
  always_comb begin
    w_final     = r_acc;
    w_final_cnt = 4'd0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (r_idx == IW'(i)) begin
        w_final[i] = dp_is_spike;
      end
    end
    for (int i = 0; i < N_NEURONS; i++) begin
      w_final_cnt = w_final_cnt + 4'(w_final[i]);
    end
  end

  // FSM, config writes and per-neuron write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sreg       <= '0;
      r_shift      <= '0;
      r_teta       <= '0;
      r_x          <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_spikes     <= '0;
      r_count      <= '0;
      r_spikes_vld <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_wreg[i] <= '0;
        r_ureg[i] <= '0;
      end
    end else begin
      r_spikes_vld <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_cfg_fire) begin
          // Weight addresses beyond the instantiated neuron count match nothing.
          for (int i = 0; i < N_NEURONS; i++) begin
            if (cfg_addr == 4'(i)) begin
              r_wreg[i] <= w_cfg_w;
            end
          end
          if (cfg_addr == 4'd8) begin
            r_shift <= cfg_data[2:0];
          end
          if (cfg_addr == 4'd9) begin
            r_teta <= w_cfg_u;
          end
          if (cfg_addr == 4'd10) begin
            r_sreg <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
              r_ureg[i] <= '0;
            end
          end
        end else if (w_step_fire) begin
          r_x     <= x;
          r_idx   <= '0;
          r_acc   <= '0;
          r_state <= S_EVAL;
        end
      end else begin
        for (int i = 0; i < N_NEURONS; i++) begin
          if (r_idx == IW'(i)) begin
            r_ureg[i] <= dp_u_out;
            r_sreg[i] <= dp_is_spike;
            r_acc[i]  <= dp_is_spike;
          end
        end
        if (w_last) begin
          r_spikes     <= w_final;
          r_count      <= w_final_cnt;
          r_spikes_vld <= 1'b1;
          r_idx        <= '0;
          r_state      <= S_IDLE;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_scheduler.sv
// Purpose: self-checking bench for neuron_scheduler with a stub LIF datapath and a step-level reference model.
// Latency: model predicts a whole step at acceptance and replays it one neuron per cycle against the DUT.
// Backpressure: the driver holds cfg_valid/step_valid until the DUT accepts them, with a bounded wait.
module tb_neuron_scheduler;
  localparam int NS = 2;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int U  = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [3:0]   cfg_addr;
  logic [7:0]   cfg_data;
  logic         step_valid;
  logic         step_ready;
  logic [W-1:0] x;
  logic [N-1:0] spikes;
  logic [3:0]   spike_count;
  logic         spikes_valid;
  logic         busy;
  logic [W-1:0] dp_w;
  logic [W-1:0] dp_x;
  logic [2:0]   dp_shift;
  logic [U-1:0] dp_previus_u;
  logic [U-1:0] dp_minus_teta;
  logic         dp_was_spike;
  logic [U-1:0] dp_u_out;
  logic         dp_is_spike;

  always #5 clk = ~clk;

  // Stub datapath: potential grows by the number of active weighted inputs, spike on MSB.
  assign dp_u_out    = dp_previus_u + U'($countones(dp_w & dp_x));
  assign dp_is_spike = dp_u_out[U-1];

  neuron_scheduler #(.n_stage(NS), .N_NEURONS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .step_valid(step_valid), .step_ready(step_ready), .x(x),
    .spikes(spikes), .spike_count(spike_count), .spikes_valid(spikes_valid), .busy(busy),
    .dp_w(dp_w), .dp_x(dp_x), .dp_shift(dp_shift), .dp_previus_u(dp_previus_u),
    .dp_minus_teta(dp_minus_teta), .dp_was_spike(dp_was_spike),
    .dp_u_out(dp_u_out), .dp_is_spike(dp_is_spike)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: whole step computed at acceptance, then replayed cycle by cycle.
  logic [W-1:0] m_w     [N];
  logic [U-1:0] m_u     [N];
  logic [U-1:0] m_u_old [N];
  logic         m_s     [N];
  logic         m_s_old [N];
  logic [2:0]   m_shift;
  logic [U-1:0] m_teta;
  logic [W-1:0] m_x;
  logic [N-1:0] m_spikes;
  logic [N-1:0] m_pend;
  int           m_count;
  int           m_rem;
  logic         m_sv;
  bit           m_init = 0;
  int           m_j;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init = 1;
      for (int i = 0; i < N; i++) begin
        m_w[i] = '0; m_u[i] = '0; m_s[i] = 1'b0; m_u_old[i] = '0; m_s_old[i] = 1'b0;
      end
      m_shift = '0; m_teta = '0; m_x = '0;
      m_spikes = '0; m_pend = '0; m_count = 0; m_rem = 0; m_sv = 1'b0;
    end else if (m_init) begin
      m_sv = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_sv     = 1'b1;
          m_spikes = m_pend;
          m_count  = $countones(m_pend);
        end
      end else if (cfg_valid) begin
        if (int'(cfg_addr) < N) m_w[cfg_addr[1:0]] = cfg_data[W-1:0];
        else if (cfg_addr == 4'd8) m_shift = cfg_data[2:0];
        else if (cfg_addr == 4'd9) m_teta = cfg_data[U-1:0];
        else if (cfg_addr == 4'd10) begin
          for (int i = 0; i < N; i++) begin m_u[i] = '0; m_s[i] = 1'b0; end
        end
      end else if (step_valid) begin
        m_x = x;
        for (int i = 0; i < N; i++) begin
          int nu;
          m_u_old[i] = m_u[i];
          m_s_old[i] = m_s[i];
          nu = (int'(m_u[i]) + $countones(m_w[i] & x)) % (1 << U);
          m_u[i]    = U'(nu);
          m_s[i]    = (nu >= (1 << (U - 1)));
          m_pend[i] = m_s[i];
        end
        m_rem = N;
      end
    end
  end

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("busy", busy, m_rem > 0);
      chk("cfg_ready", cfg_ready, m_rem == 0);
      chk("step_ready", step_ready, (m_rem == 0) && !cfg_valid);
      chk("spikes_valid", spikes_valid, m_sv);
      chk("spikes", spikes, m_spikes);
      chk("spike_count", spike_count, m_count);
      chk("dp_shift", dp_shift, m_shift);
      chk("dp_minus_teta", dp_minus_teta, m_teta);
      if (m_rem > 0) begin
        m_j = N - m_rem;
        chk("dp_w", dp_w, m_w[m_j]);
        chk("dp_x", dp_x, m_x);
        chk("dp_previus_u", dp_previus_u, m_u_old[m_j]);
        chk("dp_was_spike", dp_was_spike, m_s_old[m_j]);
      end else begin
        chk("dp_x_idle", dp_x, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_step(input logic [W-1:0] xv, output int waited);
    bit ok;
    ok = 0; waited = 0;
    step_valid = 1'b1; x = xv;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk); ok = step_ready;
      @(posedge clk); #1; waited++;
    end
    step_valid = 1'b0;
    chk("step_accepted", ok, 1);
  endtask

  task automatic do_cfg(input logic [3:0] a, input logic [7:0] d, output int waited);
    bit ok;
    ok = 0; waited = 0;
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk); ok = cfg_ready;
      @(posedge clk); #1; waited++;
    end
    cfg_valid = 1'b0;
    chk("cfg_accepted", ok, 1);
  endtask

  // Observes the N evaluation cycles following acceptance, packed neuron 0 in the low nibble.
  task automatic run_eval(output logic [15:0] cu, output logic [15:0] cw, output logic [3:0] cs);
    cu = '0; cw = '0; cs = '0;
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      cu[4*j +: 4] = dp_previus_u;
      cw[4*j +: 4] = dp_w;
      cs[j]        = dp_was_spike;
      chk("busy_in_eval", busy, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic step_and_check(input logic [W-1:0] xv, input logic [15:0] exp_u,
                                input logic [3:0] exp_ws, input logic [3:0] exp_sp,
                                input logic [3:0] exp_cnt);
    int w;
    logic [15:0] cu, cw;
    logic [3:0] cs;
    issue_step(xv, w);
    run_eval(cu, cw, cs);
    chk("lit_u_before", cu, exp_u);
    chk("lit_was_spike", cs, exp_ws);
    @(negedge clk);
    chk("lit_spikes_valid", spikes_valid, 1);
    chk("lit_spikes", spikes, exp_sp);
    chk("lit_spike_count", spike_count, exp_cnt);
    chk("lit_ready_on_done", step_ready, 1);
    tick();
  endtask

  initial begin
    int w, w2;
    logic [15:0] cu, cw;
    logic [3:0] cs;
    rst_n = 1'b0; cfg_valid = 1'b0; step_valid = 1'b0;
    cfg_addr = '0; cfg_data = '0; x = '0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_spikes", spikes, 0);
    chk("rst_count", spike_count, 0);
    chk("rst_sv", spikes_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_step_ready", step_ready, 1);
    tick();

    // Basic step and accumulation with weights F,3,1,0 and x=F
    do_cfg(4'd0, 8'h0F, w); do_cfg(4'd1, 8'h03, w);
    do_cfg(4'd2, 8'h01, w); do_cfg(4'd3, 8'h00, w);
    step_and_check(4'hF, 16'h0000, 4'b0000, 4'b0000, 4'd0);
    step_and_check(4'hF, 16'h0124, 4'b0000, 4'b0001, 4'd1);
    step_and_check(4'hF, 16'h0248, 4'b0001, 4'b0001, 4'd1);
    step_and_check(4'hF, 16'h036C, 4'b0001, 4'b0010, 4'd1);

    // Observability of globals
    do_cfg(4'd8, 8'h05, w);
    do_cfg(4'd9, 8'h0C, w);
    @(negedge clk);
    chk("lit_dp_shift", dp_shift, 5);
    chk("lit_dp_teta", dp_minus_teta, 4'hC);
    tick();

    // Config and step together: config first, step one cycle later
    cfg_valid = 1'b1; cfg_addr = 4'd10; cfg_data = 8'h00;
    step_valid = 1'b1; x = 4'hF;
    @(negedge clk);
    chk("lit_contend_step_ready", step_ready, 0);
    chk("lit_contend_cfg_ready", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("lit_contend_step_ready2", step_ready, 1);
    chk("lit_contend_busy", busy, 0);
    tick();
    step_valid = 1'b0;
    @(negedge clk);
    chk("lit_contend_busy2", busy, 1);
    chk("lit_cleared_u0", dp_previus_u, 0);
    repeat (N) tick();
    @(negedge clk);
    chk("lit_contend_sv", spikes_valid, 1);
    chk("lit_contend_spikes", spikes, 4'b0000);
    tick();

    // Requests held during EVAL wait exactly N+1 cycles
    issue_step(4'h5, w);
    issue_step(4'hA, w2);
    chk("lit_step_blocked_wait", w2, N + 1);
    do_cfg(4'd9, 8'h03, w);
    chk("lit_cfg_blocked_wait", w, N + 1);
    @(negedge clk);
    chk("lit_teta_after_block", dp_minus_teta, 4'h3);
    tick();

    // Reset during the second EVAL cycle
    issue_step(4'hF, w);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lit_rst_mid_sv", spikes_valid, 0);
      chk("lit_rst_mid_busy", busy, 0);
      tick();
    end
    issue_step(4'hF, w);
    run_eval(cu, cw, cs);
    chk("lit_rst_mid_u", cu, 16'h0000);
    chk("lit_rst_mid_w", cw, 16'h0000);
    tick();

    // Randomized traffic
    for (int i = 0; i < N; i++) do_cfg(4'(i), 8'($urandom), w);
    for (int t = 0; t < 120; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        do_cfg(4'($urandom_range(0, 15)), 8'($urandom), w);
      end else begin
        issue_step(W'($urandom), w);
        if (r > 7) repeat ($urandom_range(0, 6)) tick();
      end
    end
    repeat (N + 3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
